// File: rtl/div_x_seq.sv
// div_x_seq: sequential GF(3^593) division by x, C = B * x^(-k) mod p(x),
// p(x) = x^593 + x^112 + 2. One division per clock by default.
// Optional build macro DIV_X_DOUBLE_STEP_EN: two divisions per clock while
// at least two remain (result is identical, latency ceil(k/2)+1).
// Coefficient i lives in bits [2i+1:2i]; 00=0, 01=1, 10=2, 11 illegal.
module div_x_seq #(
  parameter int unsigned M   = 593,
  parameter int unsigned TAP = 112,
  parameter int unsigned KW  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*M-1:0]  din,
  input  logic [KW-1:0]   k,
  output logic            busy,
  output logic            done,
  output logic [2*M-1:0]  dout
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [2*M-1:0]  acc_q, acc_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  // GF(3) addition of two legal 2-bit coefficients.
  function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

  // One division by x: (B + b0*p)/x. The constant term cancels, so this is a
  // shift down with b0 folded into the top coefficient and the tap below 112.
  function automatic logic [2*M-1:0] div_x(input logic [2*M-1:0] b);
    logic [2*M-1:0] c;
    c = {2'b00, b[2*M-1:2]};
    c[2*M-1 -: 2] = b[1:0];
    c[2*(TAP-1) +: 2] = f3_add(b[2*TAP +: 2], b[1:0]);
    return c;
  endfunction

  // State, accumulator, step counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept in idle, step while count remains, then pulse done.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = din;
          cnt_d   = k;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
`ifdef DIV_X_DOUBLE_STEP_EN
          if (cnt_q >= KW'(2)) begin
            acc_d = div_x(div_x(acc_q));
            cnt_d = cnt_q - KW'(2);
          end else begin
            acc_d = div_x(acc_q);
            cnt_d = cnt_q - KW'(1);
          end
`else
          acc_d = div_x(acc_q);
          cnt_d = cnt_q - KW'(1);
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    busy = (state_q == StRun);
    done = done_q;
    dout = acc_q;
  end

endmodule
